// File: rtl/pc_ctrl_pipe_if.sv
// rtl/pc_ctrl_pipe_if.sv - EX-stage redirect and PC/return-stack status bundle for pc_ctrl_pipe
interface pc_ctrl_pipe_if #(
  parameter int PC_WIDTH = 16
);
  logic                stall;
  logic                branch;
  logic                alu_zero;
  logic                uncondbranch;
  logic                call;
  logic                ret;
  logic [PC_WIDTH-1:0] signext;
  logic [PC_WIDTH-1:0] branch_pc;
  logic [PC_WIDTH-1:0] ret_reg;
  logic [PC_WIDTH-1:0] pc;
  logic                flush;
  logic                ras_empty;
  logic                ras_full;
  logic                ras_mismatch;

  modport master (
    output stall, branch, alu_zero, uncondbranch, call, ret, signext, branch_pc, ret_reg,
    input  pc, flush, ras_empty, ras_full, ras_mismatch
  );

  modport slave (
    input  stall, branch, alu_zero, uncondbranch, call, ret, signext, branch_pc, ret_reg,
    output pc, flush, ras_empty, ras_full, ras_mismatch
  );
endinterface

// File: rtl/pc_ctrl_pipe.sv
// rtl/pc_ctrl_pipe.sv - fetch PC generation, EX redirect resolution and return-address stack
module pc_ctrl_pipe #(
  parameter int                  PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  INCR         = 4,
  parameter int                  OFFSET_SHIFT = 1,
  parameter int                  RAS_DEPTH    = 4
) (
  input logic          clock,
  input logic          reset,
  pc_ctrl_pipe_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]       r_top;
  logic [CW-1:0]       r_count;
  logic                r_mismatch;

  logic                w_take_b;
  logic                w_take_u;
  logic                w_take_r;
  logic                w_push;
  logic                w_empty;
  logic                w_full;
  logic [PC_WIDTH-1:0] w_br_target;
  logic [PC_WIDTH-1:0] w_ret_addr;
  logic [PC_WIDTH-1:0] w_next_pc;
  logic [PW-1:0]       w_top_inc;

  assign w_take_b    = bus.branch & bus.alu_zero;
  assign w_take_u    = bus.uncondbranch;
  assign w_take_r    = bus.ret;
  // BL is only meaningful together with uncondbranch; a stray call is ignored.
  assign w_push      = bus.call & bus.uncondbranch;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(RAS_DEPTH));
  // Branch targets are relative to the instruction in EX, not the fetch PC.
  assign w_br_target = bus.branch_pc + (bus.signext << OFFSET_SHIFT);
  assign w_ret_addr  = bus.branch_pc + PC_WIDTH'(INCR);
  assign w_top_inc   = r_top + PW'(1);

  assign bus.flush        = ~reset & (w_take_b | w_take_u | w_take_r);
  assign bus.pc           = r_pc;
  assign bus.ras_empty    = w_empty;
  assign bus.ras_full     = w_full;
  assign bus.ras_mismatch = r_mismatch;

  // Next-PC select: return > unconditional > conditional > stall hold > sequential.
  always_comb begin
    w_next_pc = r_pc + PC_WIDTH'(INCR);
    if (w_take_r) begin
      w_next_pc = bus.ret_reg;
    end else if (w_take_u | w_take_b) begin
      w_next_pc = w_br_target;
    end else if (bus.stall) begin
      w_next_pc = r_pc;
    end
  end

  // PC register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // Return stack: circular buffer so a push when full silently drops the oldest entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_top      <= '0;
      r_count    <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= bus.ret & (w_empty | (r_ras[r_top] != bus.ret_reg));
      if (bus.ret & w_push) begin
        if (w_empty) begin
          r_top            <= w_top_inc;
          r_ras[w_top_inc] <= w_ret_addr;
          r_count          <= CW'(1);
        end else begin
          r_ras[r_top] <= w_ret_addr;
        end
      end else if (w_push) begin
        r_top            <= w_top_inc;
        r_ras[w_top_inc] <= w_ret_addr;
        if (!w_full) begin
          r_count <= r_count + CW'(1);
        end
      end else if (bus.ret & !w_empty) begin
        r_top   <= r_top - PW'(1);
        r_count <= r_count - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_pc_ctrl_pipe.sv
// tb/tb_pc_ctrl_pipe.sv - directed vector table plus randomized run against a queue-based model
module tb_pc_ctrl_pipe;
  logic clock;
  logic reset;

  pc_ctrl_pipe_if #(.PC_WIDTH(16)) bus ();

  pc_ctrl_pipe #(
    .PC_WIDTH(16), .RESET_PC(16'h0000), .INCR(4), .OFFSET_SHIFT(1), .RAS_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst, stall, br, z, unc, call, ret;
    logic [15:0] se, bp, rr;
    logic        e_flush;
    logic [15:0] e_pc;
    logic        e_mis, e_empty, e_full;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Model state: a plain queue, back = top of stack.
  logic [15:0] m_pc;
  logic [15:0] m_q[$];
  logic        m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    reset            = v.rst;
    bus.stall        = v.stall;
    bus.branch       = v.br;
    bus.alu_zero     = v.z;
    bus.uncondbranch = v.unc;
    bus.call         = v.call;
    bus.ret          = v.ret;
    bus.signext      = v.se;
    bus.branch_pc    = v.bp;
    bus.ret_reg      = v.rr;
  endtask

  // Advances the model by one clock; returns the flush expected before the edge.
  task automatic model_step(input vec_t v, output logic e_flush);
    logic [15:0] tgt;
    logic        empty;
    e_flush = !v.rst && (v.ret || v.unc || (v.br && v.z));
    if (v.rst) begin
      m_pc = 16'h0000;
      m_q.delete();
      m_mis = 1'b0;
    end else begin
      tgt = v.bp + 16'(v.se * 2);
      if (v.ret)                m_pc = v.rr;
      else if (v.unc)           m_pc = tgt;
      else if (v.br && v.z)     m_pc = tgt;
      else if (!v.stall)        m_pc = m_pc + 16'd4;
      empty = (m_q.size() == 0);
      m_mis = v.ret && (empty || m_q[m_q.size()-1] != v.rr);
      if (v.ret && v.call && v.unc) begin
        if (empty) m_q.push_back(v.bp + 16'd4);
        else m_q[m_q.size()-1] = v.bp + 16'd4;
      end else if (v.call && v.unc) begin
        if (m_q.size() == 4) void'(m_q.pop_front());
        m_q.push_back(v.bp + 16'd4);
      end else if (v.ret && !empty) begin
        void'(m_q.pop_back());
      end
    end
  endtask

  function automatic vec_t mk(input logic rst, stall, br, z, unc, call, ret,
                              input logic [15:0] se, bp, rr,
                              input logic ef, input logic [15:0] ep,
                              input logic em, ee, eu);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.z = z; v.unc = unc; v.call = call; v.ret = ret;
    v.se = se; v.bp = bp; v.rr = rr;
    v.e_flush = ef; v.e_pc = ep; v.e_mis = em; v.e_empty = ee; v.e_full = eu;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t v;
    logic ef;
    //            rst st br z  un ca rt  se        bp        rr        fl  pc        mis emp full
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0004, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0008, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h000C, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 1, 1, 0, 1, 16'h0010, 16'h0100, 16'h0200, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0004, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0008, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0008, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0008, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h000C, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 16'hFFFE, 16'h0004, 16'h0000, 1, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'h0002, 16'h0010, 16'h0000, 1, 16'h0014, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 0, 16'h0018, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'h0010, 16'hFFF0, 16'h0000, 1, 16'h0010, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 16'h0020, 16'h0040, 16'h0000, 1, 16'h0080, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0044, 1, 16'h0044, 0, 1, 0));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 16'h0000, 16'(i * 16), 16'h0000,
                       1, 16'(i * 16), 0, 0, (i >= 4)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0054, 1, 16'h0054, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0044, 1, 16'h0044, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0034, 1, 16'h0034, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0024, 1, 16'h0024, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0014, 1, 16'h0014, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0018, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0040, 16'h0000, 1, 16'h0040, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0100, 1, 16'h0100, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0104, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 16'h0000, 16'h0200, 16'h0300, 1, 16'h0300, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0204, 1, 16'h0204, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0060, 16'h0000, 1, 16'h0060, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 16'h0000, 16'h0070, 16'h0064, 1, 16'h0064, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0074, 1, 16'h0074, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'h0006, 16'hFFF0, 16'h0000, 1, 16'hFFFC, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0500, 16'h0000, 0, 16'h0004, 0, 1, 0));

    drive(tbl[0]);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #2;
      chk($sformatf("vec%0d flush", i), 32'(bus.flush), 32'(tbl[i].e_flush));
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d pc", i), 32'(bus.pc), 32'(tbl[i].e_pc));
      chk($sformatf("vec%0d ras_mismatch", i), 32'(bus.ras_mismatch), 32'(tbl[i].e_mis));
      chk($sformatf("vec%0d ras_empty", i), 32'(bus.ras_empty), 32'(tbl[i].e_empty));
      chk($sformatf("vec%0d ras_full", i), 32'(bus.ras_full), 32'(tbl[i].e_full));
    end

    // Randomized run: first cycle is a reset so model and DUT start aligned.
    for (int n = 0; n < 400; n++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 0);
      v.rst   = (n == 0) || ($urandom_range(0, 60) == 0);
      v.stall = ($urandom_range(0, 3) == 0);
      v.br    = ($urandom_range(0, 5) == 0);
      v.z     = $urandom_range(0, 1);
      v.unc   = ($urandom_range(0, 5) == 0);
      v.call  = ($urandom_range(0, 1) == 0);
      v.ret   = ($urandom_range(0, 5) == 0);
      v.se    = 16'($urandom);
      v.bp    = 16'($urandom);
      v.rr    = 16'($urandom);
      if (m_q.size() != 0 && $urandom_range(0, 2) != 0) v.rr = m_q[m_q.size()-1];
      drive(v);
      model_step(v, ef);
      #2;
      chk("rand flush", 32'(bus.flush), 32'(ef));
      @(posedge clock);
      #1;
      chk("rand pc", 32'(bus.pc), 32'(m_pc));
      chk("rand ras_mismatch", 32'(bus.ras_mismatch), 32'(m_mis));
      chk("rand ras_empty", 32'(bus.ras_empty), 32'(m_q.size() == 0));
      chk("rand ras_full", 32'(bus.ras_full), 32'(m_q.size() == 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_ctrl_pipe.md
Name: pc_ctrl_pipe

Overview:
- Parametrised program-counter unit for the pipelined LEGLite core.
- Generates the fetch PC and resolves redirects from the EX stage: conditional branch (CBZ), unconditional branch (B/BL) and register return (BR).
- Supports pipeline stall and emits a flush to the IF/ID and ID/EX registers on a redirect.
- Contains a RAS_DEPTH-entry return-address stack that tracks BL/BR pairs and checks returns against the register value.

Parameters:
- PC_WIDTH, 16: width of the PC and all address/offset ports.
- RESET_PC, 0: PC value loaded on reset.
- INCR, 4: sequential PC increment in bytes.
- OFFSET_SHIFT, 1: left shift applied to signext to form the byte offset.
- RAS_DEPTH, 4: number of return-stack entries; power of two, at least 2.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high.
- stall, input, 1: hold the PC (hazard unit).
- branch, input, 1: EX holds a conditional branch.
- alu_zero, input, 1: EX ALU zero flag.
- uncondbranch, input, 1: EX holds B or BL.
- call, input, 1: EX holds BL; only valid with uncondbranch.
- ret, input, 1: EX holds BR.
- signext, input, PC_WIDTH: sign-extended branch offset from EX.
- branch_pc, input, PC_WIDTH: PC of the instruction currently in EX.
- ret_reg, input, PC_WIDTH: register value read for BR.
- pc, output, PC_WIDTH: current fetch PC.
- flush, output, 1: redirect taken this cycle; combinational.
- ras_empty, output, 1: return stack holds no entries.
- ras_full, output, 1: return stack holds RAS_DEPTH entries.
- ras_mismatch, output, 1: registered; high for 1 cycle after a ret whose stack top differed from ret_reg or whose stack was empty.

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - pc <= RESET_PC.
  - Stack count <= 0; ras_empty=1, ras_full=0, ras_mismatch=0.
  - Overrides every other input.
- Taken conditions:
  - take_b = branch & alu_zero.
  - take_u = uncondbranch.
  - take_r = ret.
  - flush = take_b | take_u | take_r (combinational; forced 0 while reset=1).
- Targets, all arithmetic modulo 2^PC_WIDTH:
  - Branch target = branch_pc + (signext << OFFSET_SHIFT). Relative to branch_pc, not pc.
  - Return target = ret_reg, always; the stack never overrides it.
- Next-PC priority: reset > take_r > take_u > take_b > stall (hold) > pc + INCR.
  - A redirect overrides stall in the same cycle.
  - Wrap: pc = 2^PC_WIDTH - INCR increments to 0.
- Return-address stack (circular buffer plus count, updated on the clock edge, not while reset=1):
  - call & uncondbranch pushes branch_pc + INCR.
  - If full, the push overwrites the oldest entry; count stays RAS_DEPTH.
  - ret pops the top. ras_mismatch <= (empty | top != ret_reg). A pop on empty leaves count at 0.
  - ret and call in the same cycle: replace the top with the new return address; count unchanged; if empty, treat as a push. take_r sets pc.
  - call without uncondbranch is ignored.
  - Stack updates occur regardless of stall.
- ras_mismatch is 0 in every cycle without a ret.
- Latency:
  - A redirect in cycle N means pc equals the target after the edge ending cycle N.
  - flush is asserted during cycle N.
- No state machine beyond the PC register, stack pointer/count and mismatch flag; all outputs except flush are registered.

Test Plan:
- Reset, then 3 cycles free-running -> pc 0, 4, 8, 12. Assert reset again mid-run -> pc = 0 on the next edge and flush = 0.
- stall=1 for 2 cycles at pc=8 -> pc holds 8, 8, then 12. In the same setup, branch=1, alu_zero=1, branch_pc=4, signext=16'hFFFE with stall=1 -> flush=1 and next pc = 0.
- branch=1, alu_zero=0 at pc=20 -> flush=0 and pc=24. uncondbranch=1, branch_pc=0xFFF0, signext=0x10 -> pc = 0x0010 (wrap).
- BL with uncondbranch=1, call=1, branch_pc=0x40, signext=0x20 -> pc=0x80 and the stack top is 0x44. Then ret=1, ret_reg=0x44 -> pc=0x44, ras_mismatch=0, ras_empty=1.
- 5 calls with branch_pc 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_full=1. Four rets with matching ret_reg 0x54, 0x44, 0x34, 0x24 -> no mismatch, ras_empty=1. A fifth ret with ret_reg=0x14 -> ras_mismatch=1 and pc=0x14.
- ret with ret_reg=0x100 while the stack top is 0x44 -> pc=0x100 and ras_mismatch=1 for exactly 1 cycle. ret+call together with the stack empty -> count becomes 1.
